alu_req_scheduler: RTL and testbench

Shares one combinational ALU among NUM_REQ command sources, e.g. the UART command interface plus a local test/debug source. Per requester: valid/ready command channel, round-robin arbitration, registered operands and opcode driven to the ALU, result capture after ALU_LAT cycles. The result returns on a shared response channel tagged with the requester ID. Sits between the command sources and the ALU.

---
 rtl/alu_req_scheduler_pkg.sv | 25 ++
 rtl/alu_req_scheduler_rr_arbiter.sv | 31 +++
 rtl/alu_req_scheduler.sv | 160 ++++++++++++++++
 tb/tb_alu_req_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_req_scheduler_pkg.sv
// Shared types and helpers for the ALU request scheduler: FSM state encoding,
// default widths and a constant clog2 used for parameter checks.
package alu_req_scheduler_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_OPCODE_SZ  = 6;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCEPT  = 2'd1,
        ST_EXEC    = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// Combinational round-robin select: first asserted request at ptr, ptr+1, ... wrapping.
// Zero latency; no backpressure of its own, the caller decides when to sample.
module alu_req_scheduler_rr_arbiter
    import alu_req_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               any_req_o
);

    always_comb begin
        gnt_oh_o  = '0;
        gnt_id_o  = '0;
        any_req_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any_req_o && (j == ((int'(ptr_i) + i) % NUM_REQ)) && req_i[j]) begin
                    any_req_o   = 1'b1;
                    gnt_oh_o[j] = 1'b1;
                    gnt_id_o    = ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one combinational ALU among NUM_REQ command sources.
// Latency: accept 1 cycle after valid, response ALU_LAT+2 cycles after valid; one command in flight.
module alu_req_scheduler
    import alu_req_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OPCODE_SZ  = DEF_OPCODE_SZ,
    parameter int ALU_LAT    = 1,
    parameter int ID_W       = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*OPCODE_SZ-1:0]  i_req_opcode,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_op_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_op_b,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [DATA_WIDTH-1:0]         o_op_a,
    output logic [DATA_WIDTH-1:0]         o_op_b,
    output logic [OPCODE_SZ-1:0]          o_op_code,
    input  logic [DATA_WIDTH-1:0]         i_result_data,
    output logic                          o_rsp_valid,
    output logic [ID_W-1:0]               o_rsp_id,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    input  logic [NUM_REQ-1:0]            i_rsp_ready,
    output logic                          o_busy
);

    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
        $error("alu_req_scheduler: ALU_LAT must be in 1..15");
    end
    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_nreq
        $error("alu_req_scheduler: NUM_REQ must be in 2..4");
    end
    if (ID_W < clog2(NUM_REQ)) begin : g_bad_idw
        $error("alu_req_scheduler: ID_W too narrow for NUM_REQ");
    end

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ALU_LAT - 1);

    state_e                  state_q;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         grant_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_REQ-1:0]      req_ready_q;
    logic [DATA_WIDTH-1:0]   op_a_q, op_b_q, rsp_data_q;
    logic [OPCODE_SZ-1:0]    op_code_q;
    logic                    rsp_valid_q, busy_q;
    logic [ID_W-1:0]         rsp_id_q;

    logic [NUM_REQ-1:0]      arb_oh;
    logic [ID_W-1:0]         arb_id;
    logic                    arb_any;

    logic                    sel_valid, sel_rsp_rdy;
    logic [OPCODE_SZ-1:0]    sel_opcode;
    logic [DATA_WIDTH-1:0]   sel_a, sel_b;

    alu_req_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i     (i_req_valid),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_id_o  (arb_id),
        .any_req_o (arb_any)
    );

    // Mux the granted requester's channel without variable-width bit selects.
    always_comb begin
        sel_valid   = 1'b0;
        sel_rsp_rdy = 1'b0;
        sel_opcode  = '0;
        sel_a       = '0;
        sel_b       = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (grant_q == ID_W'(n)) begin
                sel_valid   = i_req_valid[n];
                sel_rsp_rdy = i_rsp_ready[n];
                sel_opcode  = i_req_opcode[n*OPCODE_SZ +: OPCODE_SZ];
                sel_a       = i_req_op_a[n*DATA_WIDTH +: DATA_WIDTH];
                sel_b       = i_req_op_b[n*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_code_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_q     <= arb_id;
                        req_ready_q <= arb_oh;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    req_ready_q <= '0;
                    if (sel_valid) begin
                        op_code_q <= sel_opcode;
                        op_a_q    <= sel_a;
                        op_b_q    <= sel_b;
                        cnt_q     <= '0;
                        state_q   <= ST_EXEC;
                    end else begin
                        // Requester withdrew: abandon the grant, keep pointer and ALU inputs.
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAT_LAST) begin
                        rsp_data_q  <= i_result_data;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= grant_q;
                        state_q     <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (sel_rsp_rdy) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= ptr_d;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_op_a      = op_a_q;
    assign o_op_b      = op_b_q;
    assign o_op_code   = op_code_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler: one instance with ALU_LAT=1 and one with ALU_LAT=4
// behind a slow-settling ALU model.
module tb_alu_req_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // ALU_LAT = 1 instance
    logic [1:0]  req_valid;
    logic [11:0] req_opcode;
    logic [15:0] req_op_a, req_op_b;
    logic [1:0]  req_ready;
    logic [7:0]  op_a, op_b, result, rsp_data;
    logic [5:0]  op_code;
    logic        rsp_valid, busy;
    logic [1:0]  rsp_id, rsp_ready;

    // ALU_LAT = 4 instance
    logic [1:0]  req_valid2;
    logic [11:0] req_opcode2;
    logic [15:0] req_op_a2, req_op_b2;
    logic [1:0]  req_ready2;
    logic [7:0]  op_a2, op_b2, result2, rsp_data2;
    logic [5:0]  op_code2;
    logic        rsp_valid2, busy2;
    logic [1:0]  rsp_id2, rsp_ready2;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [7:0] alu(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'h20:   return a + b;
            6'h21:   return a - b;
            6'h22:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign result = alu(op_code, op_a, op_b);

    // Slow ALU: output reflects operands only after they have been stable for 3 edges.
    logic [5:0] d1_op = '0, d2_op = '0, d3_op = '0;
    logic [7:0] d1_a = '0, d2_a = '0, d3_a = '0;
    logic [7:0] d1_b = '0, d2_b = '0, d3_b = '0;
    always @(posedge clk) begin
        d1_op <= op_code2; d2_op <= d1_op; d3_op <= d2_op;
        d1_a  <= op_a2;    d2_a  <= d1_a;  d3_a  <= d2_a;
        d1_b  <= op_b2;    d2_b  <= d1_b;  d3_b  <= d2_b;
    end
    assign result2 = alu(d3_op, d3_a, d3_b);

    alu_req_scheduler #(.NUM_REQ(2), .DATA_WIDTH(8), .OPCODE_SZ(6), .ALU_LAT(1), .ID_W(2)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .i_req_opcode(req_opcode),
        .i_req_op_a(req_op_a), .i_req_op_b(req_op_b),
        .o_req_ready(req_ready), .o_op_a(op_a), .o_op_b(op_b), .o_op_code(op_code),
        .i_result_data(result), .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
        .o_rsp_data(rsp_data), .i_rsp_ready(rsp_ready), .o_busy(busy)
    );

    alu_req_scheduler #(.NUM_REQ(2), .DATA_WIDTH(8), .OPCODE_SZ(6), .ALU_LAT(4), .ID_W(2)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid2), .i_req_opcode(req_opcode2),
        .i_req_op_a(req_op_a2), .i_req_op_b(req_op_b2),
        .o_req_ready(req_ready2), .o_op_a(op_a2), .o_op_b(op_b2), .o_op_code(op_code2),
        .i_result_data(result2), .o_rsp_valid(rsp_valid2), .o_rsp_id(rsp_id2),
        .o_rsp_data(rsp_data2), .i_rsp_ready(rsp_ready2), .o_busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        req_opcode[n*6 +: 6] = op;
        req_op_a[n*8 +: 8]   = a;
        req_op_b[n*8 +: 8]   = b;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},  32'(req_ready), 32'h0);
        chk({tag, "_op_a"},   32'(op_a), 32'h0);
        chk({tag, "_op_b"},   32'(op_b), 32'h0);
        chk({tag, "_opcode"}, 32'(op_code), 32'h0);
        chk({tag, "_rspv"},   32'(rsp_valid), 32'h0);
        chk({tag, "_rspid"},  32'(rsp_id), 32'h0);
        chk({tag, "_rspd"},   32'(rsp_data), 32'h0);
        chk({tag, "_busy"},   32'(busy), 32'h0);
    endtask

    initial begin
        logic [1:0] exp_g;
        rst_n       = 1'b0;
        req_valid   = '0; req_opcode  = '0; req_op_a  = '0; req_op_b  = '0; rsp_ready  = '0;
        req_valid2  = '0; req_opcode2 = '0; req_op_a2 = '0; req_op_b2 = '0; rsp_ready2 = '0;
        #2;
        chk_all_zero("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single request on requester 0, cycle 0 = this IDLE cycle
        set_req(0, 6'h20, 8'h05, 8'h03);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        tick();
        chk("single_ready_c1", 32'(req_ready), 32'h1);
        chk("single_busy_c1", 32'(busy), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("single_ready_c2", 32'(req_ready), 32'h0);
        chk("single_opcode_c2", 32'(op_code), 32'h20);
        chk("single_opa_c2", 32'(op_a), 32'h05);
        chk("single_opb_c2", 32'(op_b), 32'h03);
        chk("single_rspv_c2", 32'(rsp_valid), 32'h0);
        tick();
        chk("single_rspv_c3", 32'(rsp_valid), 32'h1);
        chk("single_rspid_c3", 32'(rsp_id), 32'h0);
        chk("single_rspd_c3", 32'(rsp_data), 32'h08);
        tick();
        chk("single_rspv_c4", 32'(rsp_valid), 32'h0);
        chk("single_busy_c4", 32'(busy), 32'h0);

        // Contention: pointer is now 1, so grants go 1,0,1,0
        set_req(0, 6'h20, 8'h10, 8'h01);
        set_req(1, 6'h21, 8'h50, 8'h20);
        req_valid = 2'b11;
        for (int it = 0; it < 4; it++) begin
            exp_g = (it % 2 == 0) ? 2'd1 : 2'd0;
            tick();
            chk("cont_ready", 32'(req_ready), (exp_g == 2'd1) ? 32'h2 : 32'h1);
            tick();
            chk("cont_opcode", 32'(op_code), (exp_g == 2'd1) ? 32'h21 : 32'h20);
            chk("cont_opa", 32'(op_a), (exp_g == 2'd1) ? 32'h50 : 32'h10);
            tick();
            chk("cont_rspv", 32'(rsp_valid), 32'h1);
            chk("cont_rspid", 32'(rsp_id), 32'(exp_g));
            chk("cont_rspd", 32'(rsp_data), (exp_g == 2'd1) ? 32'h30 : 32'h11);
            tick();
            chk("cont_idle_rspv", 32'(rsp_valid), 32'h0);
        end

        // Backpressure on requester 1's response; requester 0's ready bit must be ignored
        rsp_ready = 2'b01;
        tick();
        chk("bp_ready", 32'(req_ready), 32'h2);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rspv", 32'(rsp_valid), 32'h1);
            chk("bp_rspid", 32'(rsp_id), 32'h1);
            chk("bp_rspd", 32'(rsp_data), 32'h30);
            chk("bp_no_accept", 32'(req_ready), 32'h0);
        end
        rsp_ready = 2'b10;
        tick();
        chk("bp_release_rspv", 32'(rsp_valid), 32'h0);
        chk("bp_release_ready", 32'(req_ready), 32'h0);
        tick();
        chk("bp_ptr_adv_ready", 32'(req_ready), 32'h1);
        rsp_ready = 2'b11;
        tick();
        chk("bp_req0_opcode", 32'(op_code), 32'h20);
        tick();
        chk("bp_req0_rspid", 32'(rsp_id), 32'h0);
        chk("bp_req0_rspd", 32'(rsp_data), 32'h11);
        req_valid = 2'b10;
        tick();

        // Protocol violation: requester 1 withdraws during ACCEPT
        tick();
        chk("viol_ready", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        tick();
        chk("viol_ready_clr", 32'(req_ready), 32'h0);
        chk("viol_busy", 32'(busy), 32'h0);
        chk("viol_opcode_kept", 32'(op_code), 32'h20);
        chk("viol_opa_kept", 32'(op_a), 32'h10);
        chk("viol_opb_kept", 32'(op_b), 32'h01);
        chk("viol_rspv", 32'(rsp_valid), 32'h0);
        set_req(1, 6'h22, 8'h0F, 8'hF0);
        req_valid = 2'b11;
        tick();
        chk("viol_ptr_kept", 32'(req_ready), 32'h2);
        tick();
        chk("exec_opcode", 32'(op_code), 32'h22);
        chk("exec_opa", 32'(op_a), 32'h0F);
        chk("exec_busy", 32'(busy), 32'h1);

        // Asynchronous reset in EXEC, away from any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_rspv_a", 32'(rsp_valid), 32'h0);
        tick();
        req_valid = 2'b10;
        chk("post_rst_rspv_e", 32'(rsp_valid), 32'h0);
        chk("post_rst_opcode", 32'(op_code), 32'h20);
        tick();
        chk("post_rst_rspv", 32'(rsp_valid), 32'h1);
        chk("post_rst_rspid", 32'(rsp_id), 32'h0);
        chk("post_rst_rspd", 32'(rsp_data), 32'h11);
        req_valid = 2'b00;
        tick();

        // ALU_LAT = 4 with a slow-settling ALU
        req_opcode2[5:0] = 6'h21;
        req_op_a2[7:0]   = 8'hFF;
        req_op_b2[7:0]   = 8'h01;
        req_valid2       = 2'b01;
        rsp_ready2       = 2'b01;
        tick();
        chk("lat4_ready_c1", 32'(req_ready2), 32'h1);
        tick();
        req_valid2 = 2'b00;
        chk("lat4_opa_c2", 32'(op_a2), 32'hFF);
        chk("lat4_rspv_c2", 32'(rsp_valid2), 32'h0);
        tick();
        tick();
        tick();
        chk("lat4_rspv_c5", 32'(rsp_valid2), 32'h0);
        tick();
        chk("lat4_rspv_c6", 32'(rsp_valid2), 32'h1);
        chk("lat4_rspid_c6", 32'(rsp_id2), 32'h0);
        chk("lat4_rspd_c6", 32'(rsp_data2), 32'hFE);
        tick();
        chk("lat4_rspv_c7", 32'(rsp_valid2), 32'h0);
        chk("lat4_busy_c7", 32'(busy2), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
